mem_access_unit: RTL and testbench

- MEM-stage load/store engine; the consumer end of the ID-stage operand path.
- Takes the effective address (base + sign-extended offset, already summed in EX), the store data (rs2 value) and the opcode.
- Drives a single-port data RAM with a valid/ready handshake, aligns and extends load data, and stalls the pipeline while a bus transaction is outstanding.

---
 rtl/mem_access_unit_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared opcode, lane-strobe and state constants for the MEM stage
package mem_access_unit_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [3:0] BYTE_EN_NONE    = 4'b0000;
    localparam logic [3:0] BYTE_EN_ALL     = 4'b1111;
    localparam logic [3:0] BYTE_EN_LO_HALF = 4'b0011;
    localparam logic [3:0] BYTE_EN_HI_HALF = 4'b1100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LW, OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
            default:                                   is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        is_store_op = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane strobes/replication for stores, extraction/extension for loads
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  write_en,
    output logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0] lane_byte;

    always_comb begin
        write_en   = BYTE_EN_NONE;
        write_data = '0;
        load_data  = '0;
        misaligned = 1'b0;
        lane_byte  = read_data[{addr_lo, 3'b000} +: 8];
        case (op)
            OP_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU: load_data = {24'b0, lane_byte};
            OP_LW: begin
                misaligned = (addr_lo != 2'b00);
                load_data  = read_data;
            end
            OP_SB: begin
                write_en   = 4'b0001 << addr_lo;
                write_data = {4{store_data[7:0]}};
            end
            OP_SH: begin
                misaligned = addr_lo[0];
                write_en   = addr_lo[1] ? BYTE_EN_HI_HALF : BYTE_EN_LO_HALF;
                write_data = {2{store_data[15:0]}};
            end
            OP_SW: begin
                misaligned = (addr_lo != 2'b00);
                write_en   = BYTE_EN_ALL;
                write_data = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine with RAM handshake and pipeline stall
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [5:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_store_data,
    output logic                  req_ready,
    output logic                  stall_request,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_load_data,
    output logic                  resp_misaligned,
    output logic                  ram_en,
    output logic [3:0]            ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic                  ram_ready,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    logic [1:0]            state_q, state_d;
    logic [5:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_mis_q, resp_mis_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  ram_en_q, ram_en_d;
    logic [3:0]            ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

    logic                  accept;
    logic [5:0]            align_op;
    logic [1:0]            align_lo;
    logic [3:0]            align_we;
    logic [31:0]           align_wdata;
    logic [31:0]           align_load;
    logic                  align_mis;

    // In IDLE the aligner looks at the incoming request; afterwards at the latched op.
    assign align_op = (state_q == ST_IDLE) ? req_op : op_q;
    assign align_lo = (state_q == ST_IDLE) ? req_addr[1:0] : off_q;

    mem_lane_align u_align (
        .op         (align_op),
        .addr_lo    (align_lo),
        .store_data (req_store_data),
        .read_data  (ram_read_data),
        .write_en   (align_we),
        .write_data (align_wdata),
        .load_data  (align_load),
        .misaligned (align_mis)
    );

    assign accept        = (state_q == ST_IDLE) && req_valid && is_mem_op(req_op);
    assign req_ready     = (state_q == ST_IDLE);
    assign stall_request = accept || (state_q == ST_BUS);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        resp_mis_d   = resp_mis_q;
        resp_data_d  = resp_data_q;
        ram_en_d     = ram_en_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = req_op;
                    off_d = req_addr[1:0];
                    if (align_mis) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                        resp_data_d  = '0;
                    end else begin
                        state_d     = ST_BUS;
                        resp_mis_d  = 1'b0;
                        ram_en_d    = 1'b1;
                        ram_we_d    = align_we;
                        ram_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        ram_wdata_d = align_wdata;
                    end
                end
            end
            ST_BUS: begin
                if (ram_ready) begin
                    state_d      = ST_RESP;
                    ram_en_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = is_store_op(op_q) ? '0 : align_load;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            off_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_data_q  <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= BYTE_EN_NONE;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            resp_valid_q <= resp_valid_d;
            resp_mis_q   <= resp_mis_d;
            resp_data_q  <= resp_data_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_load_data  = resp_data_q;
    assign ram_en          = ram_en_q;
    assign ram_write_en    = ram_we_q;
    assign ram_addr        = ram_addr_q;
    assign ram_write_data  = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam logic [5:0] LB    = 6'b100000;
    localparam logic [5:0] LBU   = 6'b100100;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SB    = 6'b101000;
    localparam logic [5:0] SH    = 6'b101001;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] ADDIU = 6'b001001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [5:0]  req_op = 6'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_store_data = 32'd0;
    logic        req_ready, stall_request, resp_valid, resp_misaligned, ram_en;
    logic [31:0] resp_load_data, ram_addr, ram_write_data;
    logic [3:0]  ram_write_en;
    logic        ram_ready = 1'b0;
    logic [31:0] ram_read_data = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_store_data  (req_store_data),
        .req_ready       (req_ready),
        .stall_request   (stall_request),
        .resp_valid      (resp_valid),
        .resp_load_data  (resp_load_data),
        .resp_misaligned (resp_misaligned),
        .ram_en          (ram_en),
        .ram_write_en    (ram_write_en),
        .ram_addr        (ram_addr),
        .ram_write_data  (ram_write_data),
        .ram_ready       (ram_ready),
        .ram_read_data   (ram_read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_is_mem(input logic [5:0] op);
        return op == LB || op == LBU || op == LW || op == SB || op == SH || op == SW;
    endfunction

    function automatic bit m_is_store(input logic [5:0] op);
        return op == SB || op == SH || op == SW;
    endfunction

    function automatic bit m_fault(input logic [5:0] op, input logic [31:0] a);
        int lo = int'(a % 4);
        if (op == LW || op == SW) return lo != 0;
        if (op == SH) return (lo % 2) != 0;
        return 0;
    endfunction

    function automatic logic [3:0] m_strobe(input logic [5:0] op, input logic [31:0] a);
        int lo = int'(a % 4);
        if (op == SB) return 4'(1 << lo);
        if (op == SH) return (lo >= 2) ? 4'd12 : 4'd3;
        if (op == SW) return 4'd15;
        return 4'd0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] d);
        if (op == SB) return (d % 256) * 32'h01010101;
        if (op == SH) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b;
        b = (rd / (32'd1 << (8 * (a % 4)))) % 256;
        if (op == LW) return rd;
        if (op == LBU) return b;
        if (op == LB) return (b >= 128) ? b + 32'hFFFFFF00 : b;
        return 32'd0;
    endfunction

    // Drives one request at a negedge and walks it to completion, checking every cycle.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input int waits, input logic [31:0] rd);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a; req_store_data = sd; ram_ready = 1'b0;
        #1;
        chk("accept_ready", req_ready, 1);
        chk("accept_stall", stall_request, m_is_mem(op));
        @(negedge clk);
        req_valid = 1'b0; req_op = 6'd0;
        #1;
        if (!m_is_mem(op)) begin
            chk("ignored_ram_en", ram_en, 0);
            chk("ignored_resp", resp_valid, 0);
            chk("ignored_ready", req_ready, 1);
            return;
        end
        if (m_fault(op, a)) begin
            chk("mis_ram_en", ram_en, 0);
            chk("mis_resp_valid", resp_valid, 1);
            chk("mis_flag", resp_misaligned, 1);
            chk("mis_stall", stall_request, 0);
            chk("mis_ready", req_ready, 0);
        end else begin
            for (int w = 0; w <= waits; w++) begin
                chk("bus_ram_en", ram_en, 1);
                chk("bus_addr", ram_addr, a & 32'hFFFFFFFC);
                chk("bus_strobe", ram_write_en, m_strobe(op, a));
                if (m_is_store(op)) chk("bus_wdata", ram_write_data, m_wdata(op, sd));
                chk("bus_stall", stall_request, 1);
                chk("bus_resp_valid", resp_valid, 0);
                if (w == waits) begin
                    ram_ready = 1'b1; ram_read_data = rd;
                end else begin
                    ram_read_data = $urandom;
                end
                @(negedge clk);
                ram_ready = 1'b0;
                #1;
            end
            chk("resp_valid", resp_valid, 1);
            chk("resp_misaligned", resp_misaligned, 0);
            chk("resp_data", resp_load_data, m_load(op, a, rd));
            chk("resp_ram_en", ram_en, 0);
            chk("resp_stall", stall_request, 0);
            chk("resp_ready", req_ready, 0);
        end
        @(negedge clk);
        #1;
        chk("post_resp_valid", resp_valid, 0);
        chk("post_ready", req_ready, 1);
    endtask

    initial begin
        logic [5:0] ops [8];
        ops[0] = LB; ops[1] = LBU; ops[2] = LW; ops[3] = SB;
        ops[4] = SH; ops[5] = SW; ops[6] = ADDIU; ops[7] = 6'b000000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mis", resp_misaligned, 0);
        chk("rst_strobe", ram_write_en, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_write_data, 0);
        chk("rst_rdata", resp_load_data, 0);
        rst = 1'b1;

        // Reset while a store is parked in BUS.
        req_valid = 1'b1; req_op = SW; req_addr = 32'h300; req_store_data = 32'h11223344;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("pre_rst_bus", ram_en, 1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_ram_en", ram_en, 0);
        chk("midrst_resp", resp_valid, 0);
        chk("midrst_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("after_rst_ready", req_ready, 1);
        chk("after_rst_ram_en", ram_en, 0);

        do_op(LW,  32'h100, 32'h0, 0, 32'hDEADBEEF);
        do_op(LB,  32'h103, 32'h0, 0, 32'h80112233);
        do_op(LBU, 32'h103, 32'h0, 0, 32'h80112233);
        do_op(LB,  32'h101, 32'h0, 0, 32'h80112233);
        do_op(SB,  32'h202, 32'h000000A5, 0, 32'h0);
        do_op(SH,  32'h202, 32'h00001234, 0, 32'h0);
        do_op(SW,  32'h300, 32'hCAFEF00D, 4, 32'h0);
        do_op(LW,  32'h102, 32'h0, 0, 32'h0);
        do_op(SH,  32'h201, 32'h5555, 0, 32'h0);
        do_op(ADDIU, 32'h10, 32'h0, 0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            do_op(ops[$urandom_range(0, 7)], $urandom, $urandom, int'($urandom_range(0, 3)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
